controle_vidas: RTL and testbench
=================================

# controle_vidas

Tracks the player ship's remaining lives from the hit counters of all enemy bullets. It sits directly downstream of the `bolainimiga` instances. It detects each new hit by differencing every bullet's 2-bit `n_batidas`, decrements lives, and runs an invulnerability/blink window after each hit. It also latches game over for the video and top-level control logic.

## Interface
Parameters:
- `N_BOLAS`, default 4: number of enemy bullets monitored.
- `VIDAS_INICIAIS`, default 3: lives loaded at reset and on restart (1..7).
- `TICK_DIV`, default 50000: CLOCK_50 cycles per 1 ms tick.
- `INVULN_MS`, default 2000: invulnerability length in ticks.
- `PISCA_MS`, default 125: blink half-period in ticks.

Ports:
- `CLOCK_50` in, 1: system clock, 50 MHz.
- `reset` in, 1: asynchronous, active-high.
- `pausa` in, 1: freezes the block.
- `reiniciarJogo` in, 1: synchronous game restart.
- `n_batidas` in, 2*N_BOLAS: packed hit counters; bullet i is at bits [2i+1:2i].
- `vidas` out, 3: lives remaining.
- `game_over` out, 1: high when lives reach 0.
- `nave_visivel` out, 1: ship draw enable (blinks while invulnerable).
- `hit_pulse` out, 1: one-cycle strobe per accepted hit event.

## Operation
- Reset values:
  - `vidas`=VIDAS_INICIAIS, `game_over`=0, `nave_visivel`=1, `hit_pulse`=0.
  - All `prev[i]`=0, state JOGANDO, tick and timers 0.
- Hit detection, every CLOCK_50 cycle:
  - `delta[i] = n_batidas[i] - prev[i]`, computed mod 4 (2-bit wrap, so 3→0 counts as 1).
  - Then `prev[i] <= n_batidas[i]`, unconditionally, in every state.
  - `soma` = sum of all `delta[i]`, width clog2(3*N_BOLAS+1).
- States:
  - JOGANDO:
    - If `soma`>0 and `pausa`=0: `vidas <= sat0(vidas - soma)` and `hit_pulse <= 1`.
    - If the new `vidas`=0, go to GAME_OVER. Otherwise go to INVULNERAVEL, with timer=INVULN_MS, blink counter=0 and `nave_visivel`=0.
  - INVULNERAVEL:
    - Deltas are absorbed, not counted, and `hit_pulse` stays 0.
    - On each tick: timer decrements, and `nave_visivel` toggles every PISCA_MS ticks.
    - When timer reaches 0: go to JOGANDO with `nave_visivel`=1.
  - GAME_OVER:
    - `game_over`=1, `nave_visivel`=0, hits ignored.
    - The state is held until `reiniciarJogo` or `reset`.
- `pausa`=1:
  - Tick counter, timers and blink are frozen; the state is held.
  - Deltas are absorbed, since the bullets freeze too.
- `reiniciarJogo`=1 (synchronous, any state, priority over hits in the same cycle):
  - `vidas`=VIDAS_INICIAIS, state JOGANDO, `game_over`=0, `nave_visivel`=1, timers cleared.
  - `prev[i]` takes the current `n_batidas`, so stale counts are not charged.
- Simultaneous hits from several bullets in one cycle: one `hit_pulse`, and `vidas` drops by the total `soma`, saturating at 0.
- `n_batidas` comes from logic clocked by CLOCK_50 and is sampled directly, with no synchronizer.

## Timing
- `n_batidas` change at cycle t → `vidas`, `hit_pulse` and the state update at t+1. `hit_pulse` is high for exactly cycle t+1.
- The 1 ms tick is a single-cycle enable, asserted every TICK_DIV cycles. It resets to phase 0 on `reset` and on `reiniciarJogo`.
- Invulnerability lasts INVULN_MS ticks ±1 tick of phase jitter; blink edges fall on tick boundaries.
- `game_over` rises in the same cycle that `vidas` becomes 0.
- Reset asserted mid-invulnerability returns all outputs to their reset values immediately (asynchronous).

## Configuration
- `CONTROLE_VIDAS_INVULN_EN` defined:
  - INVULNERAVEL state, invulnerability timer and blink logic are present, as described above.
- Not defined:
  - INVULNERAVEL state and timers are removed.
  - Every nonzero `soma` in JOGANDO decrements `vidas` immediately.
  - `nave_visivel`=1 except in GAME_OVER.
  - INVULN_MS and PISCA_MS are unused.

## Structure
- Package `controle_vidas_pkg`:
  - State enum `estado_vidas_t` {JOGANDO, INVULNERAVEL, GAME_OVER}.
  - Constants `TICK_DIV_DEFAULT`=50000 and `VIDA_W`=3.
- Sub-module `divisor_tick`: TICK_DIV counter with `enable` (driven by !pausa) and `clear` inputs, producing a 1-cycle `tick`.
- Delta/sum logic and the FSM live in `controle_vidas`.

## Test plan
All cases use N_BOLAS=4 and TICK_DIV=10 for simulation.
- Reset, then bullet 0 `n_batidas` 0→1 → next cycle `vidas`=2, `hit_pulse` high for 1 cycle, state INVULNERAVEL, `nave_visivel`=0.
- Bullet 2 goes 0→1 during invulnerability → `vidas` stays 2. After INVULN_MS ticks, state is JOGANDO and `nave_visivel`=1. Then bullet 2 goes 1→2 → `vidas`=1.
- Bullets 1 and 3 both increment in the same cycle with `vidas`=3 → `vidas`=1, a single `hit_pulse`.
- Bullet 0 goes 3→0 (wrap) with `vidas`=1 → `vidas`=0, `game_over`=1. A further increment keeps `vidas`=0.
- GAME_OVER with `n_batidas`=0b11_10_01_00, then `reiniciarJogo` for 1 cycle → `vidas`=3, `game_over`=0, and the next cycle produces no `hit_pulse`.
- `pausa`=1 while invulnerable for 500 ticks → timer and `nave_visivel` frozen; an increment during the pause is not counted.

Source files
------------

// File: rtl/controle_vidas_pkg.sv
// Shared types and constants for the lives controller of the player ship.
package controle_vidas_pkg;

  typedef enum logic [1:0] {
    JOGANDO      = 2'd0,
    INVULNERAVEL = 2'd1,
    GAME_OVER    = 2'd2
  } estado_vidas_t;

  localparam int TICK_DIV_DEFAULT = 50000;
  localparam int VIDA_W           = 3;

  // Lives minus the hits taken this cycle, clamped at zero.
  function automatic logic [VIDA_W-1:0] sat0_sub(input logic [VIDA_W-1:0] vidas,
                                                 input int                soma);
    int resto;
    resto = int'(vidas) - soma;
    if (resto <= 0) begin
      return '0;
    end else begin
      return VIDA_W'(resto);
    end
  endfunction

endpackage

// File: rtl/controle_vidas_divisor_tick.sv
// Free-running 1 ms tick generator: one-cycle tick every TICK_DIV enabled cycles.
module divisor_tick
  import controle_vidas_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Phase counter; frozen while disabled, back to phase 0 on clear.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (cnt_q == ULTIMO) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Decoded from the counter so a pause never swallows a pending tick.
  assign tick = enable && !clear && (cnt_q == ULTIMO);

endmodule

// File: rtl/controle_vidas.sv
// Lives tracker fed by the enemy bullets' hit counters.
// CONTROLE_VIDAS_INVULN_EN enables the post-hit invulnerability/blink window.
module controle_vidas
  import controle_vidas_pkg::*;
#(
  parameter int N_BOLAS        = 4,
  parameter int VIDAS_INICIAIS = 3,
  parameter int TICK_DIV       = TICK_DIV_DEFAULT,
  parameter int INVULN_MS      = 2000,
  parameter int PISCA_MS       = 125
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 pausa,
  input  logic                 reiniciarJogo,
  input  logic [2*N_BOLAS-1:0] n_batidas,
  output logic [VIDA_W-1:0]    vidas,
  output logic                 game_over,
  output logic                 nave_visivel,
  output logic                 hit_pulse
);

  localparam int SOMA_W = $clog2(3 * N_BOLAS + 1);

  logic [2*N_BOLAS-1:0] prev_q;
  logic [1:0]           delta_s [N_BOLAS];
  logic [SOMA_W-1:0]    soma_s;
  logic [VIDA_W-1:0]    vidas_q, vidas_d;
  estado_vidas_t        estado_q;
  logic                 game_over_q, nave_visivel_q, hit_pulse_q;

`ifdef CONTROLE_VIDAS_INVULN_EN
  localparam int TIMER_W = $clog2(INVULN_MS + 1);
  localparam int PISCA_W = (PISCA_MS > 1) ? $clog2(PISCA_MS + 1) : 1;

  logic [TIMER_W-1:0] timer_q;
  logic [PISCA_W-1:0] pisca_q;
  logic               tick_s;

  divisor_tick #(.TICK_DIV(TICK_DIV)) u_divisor_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (!pausa),
    .clear    (reiniciarJogo),
    .tick     (tick_s)
  );
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{32'(INVULN_MS), 32'(PISCA_MS), 32'(TICK_DIV)};
`endif

  // Per-bullet hit deltas in 2-bit modular arithmetic, so 3->0 counts as one hit.
  always_comb begin
    soma_s = '0;
    for (int i = 0; i < N_BOLAS; i++) begin
      delta_s[i] = n_batidas[2*i +: 2] - prev_q[2*i +: 2];
      soma_s     = soma_s + SOMA_W'(delta_s[i]);
    end
    vidas_d = sat0_sub(vidas_q, int'(soma_s));
  end

  // Lives FSM; prev_q always follows the counters so absorbed hits never come back.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      prev_q         <= '0;
      vidas_q        <= VIDA_W'(VIDAS_INICIAIS);
      estado_q       <= JOGANDO;
      game_over_q    <= 1'b0;
      nave_visivel_q <= 1'b1;
      hit_pulse_q    <= 1'b0;
`ifdef CONTROLE_VIDAS_INVULN_EN
      timer_q        <= '0;
      pisca_q        <= '0;
`endif
    end else if (reiniciarJogo) begin
      prev_q         <= n_batidas;
      vidas_q        <= VIDA_W'(VIDAS_INICIAIS);
      estado_q       <= JOGANDO;
      game_over_q    <= 1'b0;
      nave_visivel_q <= 1'b1;
      hit_pulse_q    <= 1'b0;
`ifdef CONTROLE_VIDAS_INVULN_EN
      timer_q        <= '0;
      pisca_q        <= '0;
`endif
    end else begin
      prev_q      <= n_batidas;
      hit_pulse_q <= 1'b0;
      if (!pausa) begin
        case (estado_q)
          JOGANDO: begin
            if (soma_s != '0) begin
              vidas_q     <= vidas_d;
              hit_pulse_q <= 1'b1;
              if (vidas_d == '0) begin
                estado_q       <= GAME_OVER;
                game_over_q    <= 1'b1;
                nave_visivel_q <= 1'b0;
              end
`ifdef CONTROLE_VIDAS_INVULN_EN
              else begin
                estado_q       <= INVULNERAVEL;
                timer_q        <= TIMER_W'(INVULN_MS);
                pisca_q        <= '0;
                nave_visivel_q <= 1'b0;
              end
`endif
            end
          end
`ifdef CONTROLE_VIDAS_INVULN_EN
          INVULNERAVEL: begin
            if (tick_s) begin
              if (timer_q <= TIMER_W'(1)) begin
                estado_q       <= JOGANDO;
                timer_q        <= '0;
                pisca_q        <= '0;
                nave_visivel_q <= 1'b1;
              end else begin
                timer_q <= timer_q - TIMER_W'(1);
                if (pisca_q == PISCA_W'(PISCA_MS - 1)) begin
                  pisca_q        <= '0;
                  nave_visivel_q <= !nave_visivel_q;
                end else begin
                  pisca_q <= pisca_q + PISCA_W'(1);
                end
              end
            end
          end
`endif
          GAME_OVER: begin
            game_over_q    <= 1'b1;
            nave_visivel_q <= 1'b0;
          end
          default: begin
            estado_q       <= JOGANDO;
            nave_visivel_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign vidas        = vidas_q;
  assign game_over    = game_over_q;
  assign nave_visivel = nave_visivel_q;
  assign hit_pulse    = hit_pulse_q;

endmodule

// File: tb/tb_controle_vidas.sv
// Bench for controle_vidas: directed scenarios plus random hits/pauses/restarts
// compared every cycle against a counting model of the lives rules.
module tb_controle_vidas;

  localparam int N_BOLAS        = 4;
  localparam int VIDAS_INICIAIS = 3;
  localparam int TICK_DIV       = 10;
  localparam int INVULN_MS      = 20;
  localparam int PISCA_MS       = 3;
`ifdef CONTROLE_VIDAS_INVULN_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic                 CLOCK_50 = 1'b0;
  logic                 reset, pausa, reiniciarJogo;
  logic [2*N_BOLAS-1:0] n_batidas;
  logic [2:0]           vidas;
  logic                 game_over, nave_visivel, hit_pulse;

  int errors = 0;
  int checks = 0;

  // Reference model state: lives, flags, remaining invulnerable ticks, tick phase.
  int m_vidas, m_left, m_blink, m_phase;
  bit m_go, m_vis, m_hit, m_inv;
  int m_prev [N_BOLAS];

  controle_vidas #(
    .N_BOLAS        (N_BOLAS),
    .VIDAS_INICIAIS (VIDAS_INICIAIS),
    .TICK_DIV       (TICK_DIV),
    .INVULN_MS      (INVULN_MS),
    .PISCA_MS       (PISCA_MS)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .pausa         (pausa),
    .reiniciarJogo (reiniciarJogo),
    .n_batidas     (n_batidas),
    .vidas         (vidas),
    .game_over     (game_over),
    .nave_visivel  (nave_visivel),
    .hit_pulse     (hit_pulse)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_vidas = VIDAS_INICIAIS;
    m_go = 1'b0; m_vis = 1'b1; m_hit = 1'b0; m_inv = 1'b0;
    m_left = 0; m_blink = 0; m_phase = 0;
    for (int i = 0; i < N_BOLAS; i++) m_prev[i] = 0;
  endfunction

  // Outcome of the next clock edge given the inputs currently applied.
  function automatic void model_step(input bit p, input bit r);
    int total;
    bit tick;
    m_hit = 1'b0;
    if (r) begin
      for (int i = 0; i < N_BOLAS; i++) m_prev[i] = int'(n_batidas[2*i +: 2]);
      m_vidas = VIDAS_INICIAIS;
      m_go = 1'b0; m_vis = 1'b1; m_inv = 1'b0;
      m_left = 0; m_blink = 0; m_phase = 0;
      return;
    end
    total = 0;
    for (int i = 0; i < N_BOLAS; i++) begin
      total += (int'(n_batidas[2*i +: 2]) - m_prev[i] + 4) % 4;
      m_prev[i] = int'(n_batidas[2*i +: 2]);
    end
    if (p) return;
    tick = (m_phase == TICK_DIV - 1);
    m_phase = (m_phase + 1) % TICK_DIV;
    if (m_go) return;
    if (m_inv) begin
      if (tick) begin
        m_left--;
        m_blink++;
        if (m_blink == PISCA_MS) begin
          m_blink = 0;
          m_vis = !m_vis;
        end
        if (m_left == 0) begin
          m_inv = 1'b0;
          m_vis = 1'b1;
        end
      end
    end else if (total > 0) begin
      m_hit = 1'b1;
      m_vidas = (total >= m_vidas) ? 0 : m_vidas - total;
      if (m_vidas == 0) begin
        m_go = 1'b1;
        m_vis = 1'b0;
      end else if (INV_EN) begin
        m_inv = 1'b1;
        m_left = INVULN_MS;
        m_blink = 0;
        m_vis = 1'b0;
      end
    end
  endfunction

  task automatic compare_all();
    check_eq("vidas", int'(vidas), m_vidas);
    check_eq("game_over", int'(game_over), int'(m_go));
    check_eq("nave_visivel", int'(nave_visivel), int'(m_vis));
    check_eq("hit_pulse", int'(hit_pulse), int'(m_hit));
  endtask

  task automatic step(input bit p, input bit r);
    pausa = p;
    reiniciarJogo = r;
    model_step(p, r);
    @(negedge CLOCK_50);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  function automatic void bump(input int i, input int k);
    n_batidas[2*i +: 2] = n_batidas[2*i +: 2] + 2'(k);
  endfunction

  initial begin
    bit p, r, vis_antes;
    reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0; n_batidas = '0;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    check_eq("reset_vidas", int'(vidas), 3);
    check_eq("reset_game_over", int'(game_over), 0);
    check_eq("reset_visivel", int'(nave_visivel), 1);
    check_eq("reset_hit", int'(hit_pulse), 0);

    // first hit from bullet 0
    bump(0, 1); step(1'b0, 1'b0);
    check_eq("first_hit_vidas", int'(vidas), 2);
    check_eq("first_hit_pulse", int'(hit_pulse), 1);
    idle(1);
    check_eq("first_hit_pulse_end", int'(hit_pulse), 0);
    bump(2, 1); step(1'b0, 1'b0);
    idle(250);
    bump(2, 1); step(1'b0, 1'b0);
    idle(250);

    // restart, then a simultaneous double hit
    step(1'b0, 1'b1);
    check_eq("restart_vidas", int'(vidas), 3);
    bump(1, 1); bump(3, 1); step(1'b0, 1'b0);
    check_eq("double_hit_vidas", int'(vidas), 1);
    check_eq("double_hit_pulse", int'(hit_pulse), 1);
    idle(1);
    check_eq("double_hit_single_pulse", int'(hit_pulse), 0);
    idle(250);

    // bullet 0 wraps 3->0 for the last life
    n_batidas[1:0] = 2'd3; step(1'b1, 1'b0);
    n_batidas[1:0] = 2'd0; step(1'b0, 1'b0);
    check_eq("wrap_vidas", int'(vidas), 0);
    check_eq("wrap_game_over", int'(game_over), 1);
    bump(1, 1); step(1'b0, 1'b0);
    check_eq("over_stays_zero", int'(vidas), 0);

    // restart with stale counters present
    n_batidas = 8'b11_10_01_00; step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_eq("restart2_vidas", int'(vidas), 3);
    check_eq("restart2_game_over", int'(game_over), 0);
    idle(1);
    check_eq("restart2_no_hit", int'(hit_pulse), 0);

    // long pause while invulnerable, with a hit absorbed mid-pause
    bump(1, 1); step(1'b0, 1'b0);
    idle(45);
    vis_antes = nave_visivel;
    for (int c = 0; c < 5000; c++) begin
      if (c == 2500) bump(3, 1);
      step(1'b1, 1'b0);
    end
    check_eq("pause_visivel_frozen", int'(nave_visivel), int'(vis_antes));
    check_eq("pause_vidas", int'(vidas), 2);
    idle(300);

    // asynchronous reset in the middle of invulnerability
    bump(0, 1); step(1'b0, 1'b0);
    idle(37);
    reset = 1'b1; n_batidas = '0;
    #1;
    check_eq("async_reset_vidas", int'(vidas), 3);
    check_eq("async_reset_visivel", int'(nave_visivel), 1);
    check_eq("async_reset_game_over", int'(game_over), 0);
    model_reset();
    @(negedge CLOCK_50);
    reset = 1'b0;
    compare_all();

    // random hits, pauses and restarts
    p = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) p = !p;
      r = (m_go && ($urandom_range(0, 29) == 0)) || ($urandom_range(0, 999) == 0);
      for (int i = 0; i < N_BOLAS; i++) begin
        if ($urandom_range(0, 79) == 0) bump(i, int'($urandom_range(1, 3)));
      end
      step(p, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
